rr_arb_mux: RTL and testbench

//   Registered N-channel round-robin arbitrating mux with valid/ready handshake.

---
 rtl/rr_arb_mux.sv | 138 +++++++++++++
 tb/tb_rr_arb_mux.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux
// Description : N-channel round-robin arbitrating mux with a valid/ready
//               handshake, an optional packet lock and one registered output
//               stage. The select comes from an internal fair arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
   parameter int _W    = 32,   // data width per channel
   parameter int _N    = 2,    // select width; channel count is 2**_N
   parameter int _LOCK = 0     // 1: hold the grant until a last=1 beat is taken
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2**_N-1:0]    in_valid,
   input  logic [_W-1:0]       in_data [2**_N],
   input  logic [2**_N-1:0]    in_last,
   output logic [2**_N-1:0]    in_ready,
   output logic                out_valid,
   output logic [_W-1:0]       out_data,
   output logic                out_last,
   output logic [_N-1:0]       out_src,
   input  logic                out_ready
);

   localparam int NC = 2**_N;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [_N-1:0]   ptr_q,   ptr_d;
   logic [_N-1:0]   lock_q,  lock_d;
   logic            valid_q, valid_d;
   logic [_W-1:0]   data_q,  data_d;
   logic            last_q,  last_d;
   logic [_N-1:0]   src_q,   src_d;

   logic            w_load;
   logic            w_granted;
   logic            w_accept;
   logic            w_last;
   logic [_N-1:0]   w_g;
   logic [_N-1:0]   w_idx;

   // Output register can take a new beat when empty or draining this cycle.
   assign w_load   = ~valid_q | out_ready;
   // No beat is taken while reset is held, regardless of the inputs.
   assign w_accept = w_granted & w_load & ~rst;
   // Without packet lock every beat closes its grant.
   assign w_last   = (_LOCK != 0) ? in_last[w_g] : 1'b1;

   // Grant selection: locked channel, or the first valid channel from ptr.
   always_comb begin
      w_g       = '0;
      w_granted = 1'b0;
      w_idx     = '0;
      if (state_q == S_LOCKED) begin
         w_g       = lock_q;
         w_granted = in_valid[lock_q];
      end else begin
         // Descending scan so the candidate closest to ptr is assigned last.
         for (int k = NC - 1; k >= 0; k--) begin
            w_idx = ptr_q + k[_N-1:0];
            if (in_valid[w_idx]) begin
               w_g       = w_idx;
               w_granted = 1'b1;
            end
         end
      end
   end

   // One-hot accept towards the granted channel only.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NC; i++) begin
         in_ready[i] = w_accept & (w_g == i[_N-1:0]);
      end
   end

   // Next-state: output register, round-robin pointer and lock FSM.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      src_d   = src_q;
      if (w_accept) begin
         valid_d = 1'b1;
         data_d  = in_data[w_g];
         last_d  = w_last;
         src_d   = w_g;
         if (w_last) begin
            // Grant ends: the channel after the winner gets first priority.
            ptr_d   = w_g + 1'b1;
            state_d = S_IDLE;
         end else begin
            state_d = S_LOCKED;
            lock_d  = w_g;
         end
      end else if (w_load) begin
         valid_d = 1'b0;
      end
   end

   // State registers with asynchronous reset; a beat in flight is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         src_q   <= src_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign out_src   = src_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_mux
// Description : Self-checking bench for rr_arb_mux; one instance without and
//               one with packet lock, checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  v    [2];
   logic [31:0] d    [2][4];
   logic [3:0]  l    [2];
   logic        ordy [2];
   logic [3:0]  ir   [2];
   logic        ov   [2];
   logic [31:0] od   [2];
   logic        ol   [2];
   logic [1:0]  os   [2];

   int errors = 0;
   int checks = 0;

   // Reference model state: pointer, lock, output register contents.
   int          mptr [2];
   int          mlch [2];
   bit          mlk  [2];
   bit          mov  [2];
   bit          mol  [2];
   logic [31:0] mdat [2];
   int          msrc [2];

   always #5 clk = ~clk;

   rr_arb_mux #(._W(32), ._N(2), ._LOCK(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(v[0]), .in_data(d[0]), .in_last(l[0]),
      .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]),
      .out_src(os[0]), .out_ready(ordy[0]));

   rr_arb_mux #(._W(32), ._N(2), ._LOCK(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(v[1]), .in_data(d[1]), .in_last(l[1]),
      .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]),
      .out_src(os[1]), .out_ready(ordy[1]));

   function automatic int grant_of(input int x);
      if (mlk[x]) return v[x][mlch[x]] ? mlch[x] : -1;
      for (int k = 0; k < 4; k++)
         if (v[x][(mptr[x] + k) % 4]) return (mptr[x] + k) % 4;
      return -1;
   endfunction

   task automatic mreset(input int x);
      mptr[x] = 0; mlch[x] = 0; mlk[x] = 0;
      mov[x] = 0; mol[x] = 0; mdat[x] = '0; msrc[x] = 0;
   endtask

   task automatic check_out(input int x);
      logic [1:0] es;
      es = 2'(msrc[x]);
      checks++;
      assert (ov[x] === mov[x]) else begin
         errors++; $error("FAIL out_valid u%0d got=%b exp=%b", x, ov[x], mov[x]);
      end
      checks++;
      assert (od[x] === mdat[x]) else begin
         errors++; $error("FAIL out_data u%0d got=%h exp=%h", x, od[x], mdat[x]);
      end
      checks++;
      assert (ol[x] === mol[x]) else begin
         errors++; $error("FAIL out_last u%0d got=%b exp=%b", x, ol[x], mol[x]);
      end
      checks++;
      assert (os[x] === es) else begin
         errors++; $error("FAIL out_src u%0d got=%0d exp=%0d", x, os[x], es);
      end
   endtask

   // One clock: check in_ready and advance the model at negedge, outputs after posedge.
   task automatic step();
      int         g;
      bit         ld;
      bit         lst;
      logic [3:0] er;
      @(negedge clk);
      for (int x = 0; x < 2; x++) begin
         g  = grant_of(x);
         ld = !mov[x] || ordy[x];
         er = (g >= 0 && ld && !rst) ? 4'(1 << g) : 4'b0000;
         checks++;
         assert (ir[x] === er) else begin
            errors++; $error("FAIL in_ready u%0d got=%b exp=%b", x, ir[x], er);
         end
         if (rst) begin
            mreset(x);
         end else if (g >= 0 && ld) begin
            lst     = (x == 1) ? l[x][g] : 1'b1;
            mov[x]  = 1;
            mdat[x] = d[x][g];
            mol[x]  = lst;
            msrc[x] = g;
            if (lst) begin
               mptr[x] = (g + 1) % 4;
               mlk[x]  = 0;
            end else begin
               mlk[x]  = 1;
               mlch[x] = g;
            end
         end else if (ld) begin
            mov[x] = 0;
         end
      end
      @(posedge clk);
      #1;
      check_out(0);
      check_out(1);
   endtask

   task automatic rand_data();
      for (int x = 0; x < 2; x++)
         for (int c = 0; c < 4; c++) d[x][c] = $urandom;
   endtask

   // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      mreset(0); mreset(1);
      check_out(0); check_out(1);
      step();
      rst = 1'b0;
   endtask

   logic [3:0] lk_v [7];
   logic [3:0] lk_l [7];

   initial begin
      rst = 1'b1;
      for (int x = 0; x < 2; x++) begin
         v[x] = 4'hF; l[x] = 4'h0; ordy[x] = 1'b1; mreset(x);
      end
      rand_data();
      #1;
      check_out(0); check_out(1);
      step(); step();
      rst = 1'b0;

      // Fairness on the unlocked instance: all channels valid.
      v[1] = 4'h0;
      for (int i = 0; i < 10; i++) begin rand_data(); step(); end

      // Wrap: move ptr to 3, then only channels 3 and 0 valid.
      v[0] = 4'b0100; rand_data(); step();
      v[0] = 4'b1001;
      for (int i = 0; i < 4; i++) begin rand_data(); step(); end

      // Backpressure then release with no bubble.
      v[0] = 4'hF; ordy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin rand_data(); step(); end
      ordy[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin rand_data(); step(); end

      // Packet lock: ch1 three beats with a 2-cycle gap, ch2 valid throughout.
      v[0] = 4'h0;
      lk_v = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b0100, 4'b0000};
      lk_l = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
      for (int i = 0; i < 7; i++) begin
         v[1] = lk_v[i]; l[1] = lk_l[i]; rand_data(); step();
      end

      // Reset mid-packet, then ch0 must win first after release.
      v[1] = 4'b0110; l[1] = 4'b0000; rand_data(); step();
      async_reset();
      v[1] = 4'b0011;
      for (int i = 0; i < 3; i++) begin rand_data(); step(); end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         for (int x = 0; x < 2; x++) begin
            v[x]    = 4'($urandom);
            l[x]    = 4'($urandom);
            ordy[x] = ($urandom % 4) != 0;
         end
         rand_data();
         if (i % 97 == 50) async_reset();
         else step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
